// File: rtl/dataframe_readout_ctrl.sv
// rtl/dataframe_readout_ctrl.sv - lpGBT dataframe FIFO readout sequencer with shadow frame and counters
//
// Pops one frame from the dataframe FIFO, holds it stable in frame_o until
// software releases it, and can drain the FIFO on request.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock, async active-low reset
//   fifo_dout/empty/full        FIFO read side; fifo_rd_en registered pop strobe
//   enable_i                    level, allows automatic popping
//   release_i, flush_i          pulses: frame read done / discard and drain
//   clr_counters_i              pulse, zeroes all counters
//   frame_o, frame_valid_o      held frame and its valid flag
//   busy_o                      high in POP, WAIT or FLUSH
//   frame_count_o               frames captured (wraps)
//   flush_count_o               frames popped by flush (wraps)
//   full_events_o               fifo_full rising edges (saturates)
module dataframe_readout_ctrl #(
  parameter int DATA_W     = 234,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 32,
  parameter int EVT_W      = 16
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  output logic              fifo_rd_en,
  input  logic              enable_i,
  input  logic              release_i,
  input  logic              flush_i,
  input  logic              clr_counters_i,
  output logic [DATA_W-1:0] frame_o,
  output logic              frame_valid_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  frame_count_o,
  output logic [CNT_W-1:0]  flush_count_o,
  output logic [EVT_W-1:0]  full_events_o
);

  typedef enum logic [2:0] {IDLE, POP, WAIT, HOLD, FLUSH} state_t;

  state_t     state_q, state_d;
  logic [1:0] lat_q, lat_d;
  logic       flush_pend_q, flush_pend_d;  // flush seen while a read is in flight
  logic       gap_q, gap_d;                // FLUSH phase: 0 = issue, 1 = gap
  logic       rd_en_d;
  logic       valid_d;
  logic       capture;
  logic       flush_pop;
  logic       full_q;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    flush_pend_d = flush_pend_q;
    gap_d        = gap_q;
    valid_d      = frame_valid_o;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          gap_d   = 1'b0;
        end else if (enable_i && !fifo_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = WAIT;
        lat_d   = 2'd0;
        if (flush_i) flush_pend_d = 1'b1;
      end
      WAIT: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (lat_q == 2'(RD_LATENCY - 1)) begin
          // The in-flight frame is always captured and counted; a pending
          // flush only decides whether it becomes visible.
          capture = 1'b1;
          if (flush_pend_q || flush_i) begin
            state_d      = FLUSH;
            gap_d        = 1'b0;
            flush_pend_d = 1'b0;
          end else begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      HOLD: begin
        if (flush_i) begin
          state_d = FLUSH;
          gap_d   = 1'b0;
          valid_d = 1'b0;
        end else if (release_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      FLUSH: begin
        // The gap cycle lets fifo_empty reflect the previous pop before the
        // exit decision is made.
        if (!gap_q) begin
          gap_d = 1'b1;
        end else if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          gap_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered pop decision: only ever taken on a sample of fifo_empty=0.
    flush_pop = (state_d == FLUSH) && !gap_d && !fifo_empty;
    rd_en_d   = (state_d == POP) || flush_pop;
  end

  assign busy_o = (state_q == POP) || (state_q == WAIT) || (state_q == FLUSH);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= IDLE;
      lat_q         <= 2'd0;
      flush_pend_q  <= 1'b0;
      gap_q         <= 1'b0;
      fifo_rd_en    <= 1'b0;
      frame_o       <= '0;
      frame_valid_o <= 1'b0;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      flush_pend_q  <= flush_pend_d;
      gap_q         <= gap_d;
      fifo_rd_en    <= rd_en_d;
      frame_valid_o <= valid_d;
      full_q        <= fifo_full;
      if (capture) frame_o <= fifo_dout;
    end
  end

  // full_q is deliberately left alone by clr_counters_i so a clear while
  // fifo_full is high does not produce a fresh edge afterwards.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      frame_count_o <= '0;
      flush_count_o <= '0;
      full_events_o <= '0;
    end else if (clr_counters_i) begin
      frame_count_o <= '0;
      flush_count_o <= '0;
      full_events_o <= '0;
    end else begin
      if (capture)   frame_count_o <= frame_count_o + 1'b1;
      if (flush_pop) flush_count_o <= flush_count_o + 1'b1;
      if (fifo_full && !full_q && (full_events_o != '1))
        full_events_o <= full_events_o + 1'b1;
    end
  end

endmodule

// File: doc/dataframe_readout_ctrl.md
Name: dataframe_readout_ctrl

Overview:
- Sequences readout of the 234-bit lpGBT dataframe FIFO on the AXI clock side.
- Pops one frame when software is ready, holds it stable in a shadow register for word-by-word AXI reads, and releases it on an explicit release pulse (read of the last word).
- Adds flush, frame and full-event counters, so the register bank never sees a frame change mid-read.

Parameters:
- DATA_W, 234, FIFO frame width.
- RD_LATENCY, 1, cycles from fifo_rd_en to valid fifo_dout; legal range 1..3.
- CNT_W, 32, width of frame_count_o and flush_count_o.
- EVT_W, 16, width of full_events_o.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- fifo_dout  in  DATA_W  FIFO read data.
- fifo_empty  in  1  FIFO empty flag, read domain.
- fifo_full  in  1  FIFO full flag, treated as synchronous to S_AXI_ACLK.
- fifo_rd_en  out  1  FIFO pop strobe, registered.
- enable_i  in  1  level; allows automatic popping.
- release_i  in  1  pulse; software finished reading the held frame.
- flush_i  in  1  pulse; discard held frame and drain FIFO.
- clr_counters_i  in  1  pulse; zero all counters.
- frame_o  out  DATA_W  held frame.
- frame_valid_o  out  1  frame_o holds an unreleased frame.
- busy_o  out  1  high in POP, WAIT or FLUSH.
- frame_count_o  out  CNT_W  frames captured, wraps.
- flush_count_o  out  CNT_W  frames discarded by flush, wraps.
- full_events_o  out  EVT_W  fifo_full rising edges, saturating.

Behaviour:
- Reset (ARESETN low, async):
  - state=IDLE; fifo_rd_en=0; frame_o=0; frame_valid_o=0; busy_o=0.
  - All counters 0; latency counter 0; full-edge register 0.
- States: IDLE, POP, WAIT, HOLD, FLUSH.
- IDLE:
  - If flush_i: go to FLUSH.
  - Else if enable_i=1 and fifo_empty=0: go to POP.
- POP (exactly 1 cycle): fifo_rd_en=1; go to WAIT.
- WAIT:
  - Lasts RD_LATENCY cycles.
  - On the last WAIT edge: frame_o<=fifo_dout, frame_valid_o<=1, frame_count_o+1, go to HOLD.
  - Latency: conditions seen at edge N give rd_en high in cycle N+1 and frame_valid_o high from cycle N+2+RD_LATENCY.
- HOLD:
  - frame_o stays constant.
  - release_i: frame_valid_o<=0, go to IDLE. The next pop can start the cycle after IDLE is entered.
  - enable_i=0 has no effect in HOLD.
- release_i outside HOLD is ignored.
- flush_i priority:
  - flush_i in IDLE or HOLD, or simultaneous with release_i: flush wins.
  - frame_valid_o<=0; frame_o keeps its last value; go to FLUSH.
  - flush_i during POP/WAIT is latched. The in-flight frame is captured as normal (counted in frame_count_o), then immediately discarded and FLUSH entered instead of HOLD. frame_valid_o never rises for that frame.
- FLUSH:
  - Alternates issue/gap cycles.
  - On an issue cycle with fifo_empty=0: fifo_rd_en=1 and flush_count_o+1.
  - Exit to IDLE on a gap cycle that samples fifo_empty=1.
  - enable_i is ignored in FLUSH.
- Pop guard: fifo_rd_en is never asserted in a cycle whose registered decision sampled fifo_empty=1.
- busy_o: combinational decode of state ∈ {POP, WAIT, FLUSH}.
- full_events_o: increments on each 0→1 transition of fifo_full (registered edge detect); saturates at all-ones.
- Counter arithmetic:
  - frame_count_o and flush_count_o wrap modulo 2^CNT_W.
  - clr_counters_i zeroes all three counters next edge and takes priority over a simultaneous increment.
  - The edge-detect register is not cleared, so no spurious event is generated.
- Reset asserted mid-operation: immediate return to reset values. An in-flight FIFO read is abandoned and the data is lost; this is acceptable.

Test Plan:
- Reset, fifo_empty=0 with frame A, enable_i=1 → one rd_en pulse 1 cycle after enable is sampled; frame_valid_o=1 at +3 cycles (RD_LATENCY=1); frame_o=A; frame_count_o=1.
- Hold A, FIFO now presents B, 5 cycles without release_i → frame_o stays A and no rd_en. Then release_i → frame_valid_o low, B captured 4 cycles later, frame_count_o=2.
- FIFO holds 3 frames, flush_i pulse in IDLE → exactly 3 rd_en pulses spaced 2 cycles apart; flush_count_o=3; return to IDLE; frame_valid_o=0 throughout.
- flush_i and release_i asserted in the same HOLD cycle → FLUSH is entered and flush_count_o advances; no new frame is captured before the FIFO is empty.
- Toggle fifo_full 0→1→0→1 → full_events_o=2. Preload the counter to 0xFFFE, apply 3 more edges → 0xFFFF. clr_counters_i → all counters 0.
- Assert ARESETN low asynchronously during WAIT → outputs reach reset values before the next clock edge; after release with enable_i=1 and FIFO non-empty, normal popping resumes.
